// File: rtl/sha256_msg_padder.sv
// sha256_msg_padder: applies SHA-256 padding to a byte stream and frames 64-byte blocks for the core.
// Define PADDER_PINGPONG_EN for two block buffers so filling overlaps sending.
module sha256_msg_padder #(
  parameter int LEN_W      = 32,
  parameter int GAP_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  input  logic       s_empty,
  output logic       s_ready,
  output logic [7:0] core_data,
  output logic       core_we,
  output logic       core_first,
  output logic       core_last,
  input  logic       core_busy,
  output logic       pad_busy
);
`ifdef PADDER_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif
  localparam logic PP = (NB == 2);
  localparam int GW = $clog2(GAP_CYCLES + 2);
  typedef enum logic [1:0] {FILL, PAD, LENBLK} fill_t;
  typedef enum logic [1:0] {WAIT, SETUP, SEND} send_t;
  fill_t r_fst, w_fst_nx;
  send_t r_sst, w_sst_nx;
  logic [7:0] r_buf [NB][64];
  logic r_full [NB];
  logic r_bfirst [NB];
  logic r_bfinal [NB];
  logic r_wsel, r_rsel, r_run, r_active, r_msg_first, r_mark, r_short;
  logic [5:0] r_idx, r_scnt;
  logic [LEN_W-1:0] r_cnt;
  logic [GW-1:0] r_gap;
  logic w_free, w_acc, w_wr, w_done, w_short, w_final, w_go, w_send_end, w_b0;
  logic [7:0] w_wdata, w_lenb, w_lenz;
  logic [63:0] w_bits;
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_fst <= FILL;
      r_sst <= WAIT;
      r_run <= 1'b0;
    end else begin
      r_fst <= w_fst_nx;
      r_sst <= w_sst_nx;
      r_run <= 1'b1;
    end
  end
  always_comb begin
    w_free     = !r_full[r_wsel];
    s_ready    = r_run && r_fst == FILL && w_free;
    w_acc      = s_valid && s_ready;
    w_short    = r_mark ? r_short : (r_idx[5:3] != 3'd7);
    w_wr       = (r_fst == FILL) ? (w_acc && !(s_last && s_empty)) : w_free;
    w_done     = w_wr && r_idx == 6'd63;
    w_final    = r_fst == LENBLK || (r_fst == PAD && w_short);
    w_bits     = 64'({r_cnt, 3'b000});
    w_lenb     = 8'(w_bits >> {~r_idx[2:0], 3'b000});
    w_lenz     = (r_idx[5:3] == 3'd7) ? w_lenb : 8'h00;
    // 0x80 goes on the first PAD write; length bytes land in slots 56..63 of the final block
    w_wdata    = (r_fst == FILL) ? s_data :
                 (r_fst == PAD && !r_mark) ? 8'h80 :
                 (r_fst == LENBLK || r_short) ? w_lenz : 8'h00;
    w_fst_nx   = (r_fst == FILL) ? ((w_acc && s_last) ? PAD : FILL) :
                 !w_done ? r_fst :
                 (r_fst == PAD && !w_short) ? LENBLK : FILL;
  end
  always_comb begin
    w_go       = r_full[r_rsel] && (r_bfirst[r_rsel] ? !core_busy : r_gap >= GW'(GAP_CYCLES));
    w_send_end = r_sst == SEND && r_scnt == 6'd63;
    w_sst_nx   = (r_sst == WAIT) ? (w_go ? (r_bfirst[r_rsel] ? SETUP : SEND) : WAIT) :
                 (r_sst == SETUP) ? SEND :
                 w_send_end ? WAIT : SEND;
  end
  always_comb begin
    core_we    = r_sst == SEND;
    w_b0       = core_we && r_scnt == 6'd0;
    core_data  = core_we ? r_buf[r_rsel][r_scnt] : 8'h00;
    core_first = r_sst == SETUP || (w_b0 && r_bfirst[r_rsel]);
    core_last  = w_b0 && r_bfinal[r_rsel];
    pad_busy   = r_active || r_full[0] || r_full[NB-1];
  end
  always_ff @(posedge clk) begin
    if (w_wr) r_buf[r_wsel][r_idx] <= w_wdata;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_idx       <= '0;
      r_scnt      <= '0;
      r_cnt       <= '0;
      r_gap       <= '0;
      r_wsel      <= 1'b0;
      r_rsel      <= 1'b0;
      r_active    <= 1'b0;
      r_msg_first <= 1'b1;
      r_mark      <= 1'b0;
      r_short     <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        r_full[i]   <= 1'b0;
        r_bfirst[i] <= 1'b0;
        r_bfinal[i] <= 1'b0;
      end
    end else begin
      if (w_wr) r_idx <= r_idx + 6'd1;
      if (w_wr && r_fst == FILL) r_cnt <= r_cnt + LEN_W'(1);
      if (w_acc) r_active <= 1'b1;
      if (w_wr && r_fst == PAD && !r_mark) begin
        r_mark  <= 1'b1;
        r_short <= w_short;
      end
      r_scnt <= core_we ? r_scnt + 6'd1 : 6'd0;
      r_gap  <= w_send_end ? '0 : (r_gap >= GW'(GAP_CYCLES)) ? r_gap : r_gap + GW'(1);
      if (w_send_end) begin
        r_full[r_rsel] <= 1'b0;
        r_rsel         <= r_rsel ^ PP;
      end
      if (w_done) begin
        r_full[r_wsel]   <= 1'b1;
        r_bfirst[r_wsel] <= r_msg_first;
        r_bfinal[r_wsel] <= w_final;
        r_wsel           <= r_wsel ^ PP;
        r_msg_first      <= w_final;
        r_mark           <= 1'b0;
        if (w_final) begin
          r_active <= 1'b0;
          r_cnt    <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_sha256_msg_padder.sv
// tb_sha256_msg_padder: scoreboard bench for sha256_msg_padder padding and block framing.
module tb_sha256_msg_padder;
  logic clk = 1'b0, reset = 1'b0;
  logic [7:0] s_data = 8'h00;
  logic s_valid = 1'b0, s_last = 1'b0, s_empty = 1'b0, core_busy = 1'b0;
  logic s_ready, core_we, core_first, core_last, pad_busy;
  logic [7:0] core_data;
  int checks = 0, passes = 0, gap = 100;
  logic [10:0] exp_q[$];
  logic [7:0] msg[$];

  always #5 clk = ~clk;

  sha256_msg_padder dut (
    .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_empty(s_empty), .s_ready(s_ready), .core_data(core_data), .core_we(core_we),
    .core_first(core_first), .core_last(core_last), .core_busy(core_busy), .pad_busy(pad_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Reference padding: message, 0x80, zeros to 56 mod 64, then 64-bit big-endian bit count.
  task automatic expect_msg();
    logic [7:0] p[$];
    logic [63:0] bits;
    int nb;
    p = msg;
    bits = 64'(msg.size()) << 3;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    nb = p.size() / 64;
    for (int b = 0; b < nb; b++) begin
      if (b == 0) exp_q.push_back({3'b010, 8'h00});
      for (int i = 0; i < 64; i++)
        exp_q.push_back({1'b1, b == 0 && i == 0, b == nb - 1 && i == 0, p[b*64+i]});
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic e, input bit tog);
    int t = 0;
    s_data = d; s_last = l; s_empty = e; s_valid = 1'b1;
    while (!s_ready && t < 5000) begin @(negedge clk); t++; end
    if (t == 5000) chk("s_ready_timeout", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_empty = 1'b0; s_data = 8'h00;
    if (tog) @(negedge clk);
  endtask

  task automatic send(input bit tog);
    expect_msg();
    if (msg.size() == 0) beat(8'h00, 1'b1, 1'b1, tog);
    else for (int i = 0; i < msg.size(); i++) beat(msg[i], i == msg.size() - 1, 1'b0, tog);
  endtask

  task automatic fill(input int n, input logic [7:0] v);
    msg.delete();
    repeat (n) msg.push_back(v);
  endtask

  task automatic drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
    repeat (5) @(negedge clk);
    chk("pad_busy_done", pad_busy, 0);
  endtask

  always @(negedge clk) begin
    if (core_we && !core_first && gap > 0) chk("gap", gap >= 3, 1);
    if (core_we || core_first || core_last) begin
      if (exp_q.size() == 0) chk("unexpected", {core_we, core_first, core_last, core_data}, 0);
      else chk("core", {core_we, core_first, core_last, core_data}, exp_q.pop_front());
    end
    gap = core_we ? 0 : gap + 1;
  end

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_outs", {s_ready, core_we, core_first, core_last, pad_busy, core_data}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("ready_after_rst", s_ready, 1);
    fill(56, 8'h30); send(1'b0);
    chk("pad_busy_active", pad_busy, 1);
    drain();
    fill(120, 8'h30); send(1'b0); drain();
    msg = '{8'h61, 8'h62, 8'h63}; send(1'b0); drain();
    msg.delete(); send(1'b0); drain();
    fill(64, 8'h5a); send(1'b0); drain();
    fill(55, 8'h41); send(1'b0); drain();
    core_busy = 1'b1;
    msg = '{8'h61, 8'h62, 8'h63}; send(1'b0);
    repeat (100) @(negedge clk);
    chk("busy_hold", exp_q.size(), 65);
    chk("busy_pad_busy", pad_busy, 1);
    core_busy = 1'b0;
    drain();
    fill(56, 8'h30); send(1'b1); drain();
    fill(56, 8'h30); send(1'b0);
    t = 0;
    while (exp_q.size() > 98 && t < 5000) begin @(negedge clk); t++; end
    chk("mid_send", core_we, 1);
    reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_outs", {s_ready, core_we, core_first, core_last, pad_busy, core_data}, 0);
    exp_q.delete();
    reset = 1'b1;
    repeat (200) @(negedge clk);
    chk("idle_after_rst", {core_we, pad_busy}, 0);
    msg = '{8'h61, 8'h62, 8'h63}; send(1'b0); drain();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
